// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

  localparam int unsigned BAUD_W    = 18;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: latches the period at frame start and pulses bit_done on the last clock of each bit.
module uart_bit_timer #(
  parameter int unsigned BAUD_W = uart_pkg::BAUD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic [BAUD_W-1:0] baud,
  output logic              bit_done
);

  logic [BAUD_W-1:0] period;
  logic [BAUD_W-1:0] count;

  assign bit_done = run && (count == period - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      period <= '0;
      count  <= '0;
    end else if (start) begin
      // A zero divisor is treated as one clock per bit
      period <= (baud == '0) ? BAUD_W'(1) : baud;
      count  <= '0;
    end else if (run) begin
      if (bit_done) count <= '0;
      else          count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 7/8 data bits LSB first, optional parity, stop bit.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_W = uart_pkg::BAUD_W,
  parameter int unsigned DATA_W = uart_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BAUD_W-1:0] Baud_val,
  input  logic              Load,
  input  logic [DATA_W-1:0] Out_port,
  input  logic              Eight,
  input  logic              Pen,
  input  logic              Ohel,
  output logic              Tx,
  output logic              TxRdy,
  output logic              Done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] masked;
  logic [CNT_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  last_bit;
  logic              eight_q;
  logic              pen_q;
  logic              par_q;
  logic              accept;
  logic              bit_done;

  assign accept   = Load && TxRdy;
  assign last_bit = eight_q ? CNT_W'(DATA_W - 1) : CNT_W'(DATA_W - 2);

  always_comb begin
    masked = Out_port;
    if (!Eight) masked[DATA_W-1] = 1'b0;
  end

  uart_bit_timer #(.BAUD_W(BAUD_W)) u_timer (
    .clk      (Clk),
    .rst      (Rst),
    .start    (accept),
    .run      (state != IDLE),
    .baud     (Baud_val),
    .bit_done (bit_done)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      Tx      <= 1'b1;
      TxRdy   <= 1'b1;
      Done    <= 1'b0;
      shreg   <= '0;
      bitcnt  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= masked;
            eight_q <= Eight;
            pen_q   <= Pen;
            par_q   <= (^masked) ^ Ohel;
            Tx      <= 1'b0;
            TxRdy   <= 1'b0;
            bitcnt  <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            Tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bitcnt == last_bit) begin
              bitcnt <= '0;
              if (pen_q) begin
                Tx    <= par_q;
                state <= PARITY;
              end else begin
                Tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              Tx     <= shreg[0];
              shreg  <= shreg >> 1;
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            Tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          // bitcnt is reused to count stop bits
          if (bit_done) begin
            if (bitcnt == CNT_W'(STOP_BITS - 1)) begin
              bitcnt <= '0;
              TxRdy  <= 1'b1;
              Done   <= 1'b1;
              state  <= IDLE;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
